// File: rtl/ladybird_alu_arbiter.sv
// ladybird_alu_arbiter: one ladybird_alu shared by N_REQ requesters.
//   Round-robin grant with an optional per-requester lock.
//   The result is registered: one op in flight, 1-cycle latency, and 1 op/cycle
//   when each result is drained in the cycle it is presented.
// Optional feature macro: LADYBIRD_ALU_ARB_PERF_EN (PERF_ACCEPT / PERF_STALL counters).
// Ports:
//   CLK, RESET          clock, asynchronous active-high reset
//   REQ_VALID/READY     per-requester operation handshake
//   REQ_LOCK            keep the grant after the current op
//   REQ_OPERATION/ALTERNATE/SRC1/SRC2  per-requester ALU operands
//   RSP_VALID/READY     per-requester result handshake
//   RSP_Q               shared result data
//   BUSY                result pending or lock held

// ladybird_alu: combinational RV-style integer ALU (funct3 encoding, alternate = sub/sra).
module ladybird_alu #(
  parameter int unsigned XLEN          = 32,
  parameter bit          USE_FA_MODULE = 1'b1
) (
  input  logic [2:0]      operation,
  input  logic            alternate,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic [XLEN-1:0] q
);
  localparam int unsigned SH_W = $clog2(XLEN);

  logic            sub;
  logic [XLEN-1:0] add_b;
  logic [XLEN-1:0] sum;
  logic [SH_W-1:0] shamt;

  assign sub   = (operation == 3'd0) & alternate;
  assign add_b = src2 ^ {XLEN{sub}};
  assign shamt = src2[SH_W-1:0];

  // Adder: explicit ripple of full adders, or a behavioural '+'.
  if (USE_FA_MODULE) begin : g_fa
    logic [XLEN-1:0] carry;
    assign carry[0] = sub;
    for (genvar i = 0; i < XLEN; i++) begin : g_bit
      assign sum[i] = src1[i] ^ add_b[i] ^ carry[i];
      if (i < XLEN - 1) begin : g_c
        assign carry[i+1] = (src1[i] & add_b[i]) | (carry[i] & (src1[i] ^ add_b[i]));
      end
    end
  end else begin : g_beh
    assign sum = src1 + add_b + XLEN'(sub);
  end

  // Result select.
  always_comb begin
    q = '0;
    case (operation)
      3'd0:    q = sum;
      3'd1:    q = src1 << shamt;
      3'd2:    q = XLEN'($signed(src1) < $signed(src2));
      3'd3:    q = XLEN'(src1 < src2);
      3'd4:    q = src1 ^ src2;
      3'd5:    q = alternate ? XLEN'($signed(src1) >>> shamt) : (src1 >> shamt);
      3'd6:    q = src1 | src2;
      default: q = src1 & src2;
    endcase
  end
endmodule

module ladybird_alu_arbiter #(
  parameter int          N_REQ         = 2,
  parameter int unsigned XLEN          = 32,
  parameter bit          USE_FA_MODULE = 1'b1,
  parameter bit          SIMULATION    = 1'b0
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [N_REQ-1:0]           REQ_VALID,
  output logic [N_REQ-1:0]           REQ_READY,
  input  logic [N_REQ-1:0]           REQ_LOCK,
  input  logic [N_REQ-1:0][2:0]      REQ_OPERATION,
  input  logic [N_REQ-1:0]           REQ_ALTERNATE,
  input  logic [N_REQ-1:0][XLEN-1:0] REQ_SRC1,
  input  logic [N_REQ-1:0][XLEN-1:0] REQ_SRC2,
  output logic [N_REQ-1:0]           RSP_VALID,
  input  logic [N_REQ-1:0]           RSP_READY,
  output logic [XLEN-1:0]            RSP_Q,
  output logic                       BUSY
`ifdef LADYBIRD_ALU_ARB_PERF_EN
  ,
  output logic [N_REQ-1:0][31:0]     PERF_ACCEPT,
  output logic [31:0]                PERF_STALL
`endif
);
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [XLEN-1:0]  q_r;
  logic [IDX_W-1:0] own, rr, lock_own, gidx, rr_next;
  logic             rsp_pend, locked;
  logic             drain, slot_free, accept;
  logic [N_REQ-1:0] grant;
  int               rr_dist, rr_best;

  logic [2:0]       alu_op;
  logic             alu_alt;
  logic [XLEN-1:0]  alu_a, alu_b, alu_q;

  assign drain     = rsp_pend & RSP_READY[own];
  assign slot_free = ~rsp_pend | drain;

  // Grant: lock owner only while locked, else first valid at or after rr (cyclic).
  always_comb begin
    grant   = '0;
    rr_dist = 0;
    rr_best = N_REQ;
    if (locked) begin
      for (int i = 0; i < N_REQ; i++) begin
        if ((IDX_W'(i) == lock_own) && REQ_VALID[i]) grant[i] = 1'b1;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        rr_dist = (i >= int'(rr)) ? (i - int'(rr)) : (i + N_REQ - int'(rr));
        if (REQ_VALID[i] && (rr_dist < rr_best)) begin
          rr_best = rr_dist;
          grant   = '0;
          grant[i] = 1'b1;
        end
      end
    end
  end

  // Encode grant and steer the granted requester's operands into the ALU.
  always_comb begin
    gidx    = '0;
    alu_op  = '0;
    alu_alt = 1'b0;
    alu_a   = '0;
    alu_b   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        gidx    = IDX_W'(i);
        alu_op  = REQ_OPERATION[i];
        alu_alt = REQ_ALTERNATE[i];
        alu_a   = REQ_SRC1[i];
        alu_b   = REQ_SRC2[i];
      end
    end
  end

  assign REQ_READY = RESET ? '0 : (grant & {N_REQ{slot_free}});
  assign accept    = |REQ_READY;
  assign rr_next   = (gidx == IDX_W'(N_REQ - 1)) ? '0 : gidx + IDX_W'(1);

  ladybird_alu #(
    .XLEN          (XLEN),
    .USE_FA_MODULE (USE_FA_MODULE)
  ) u_alu (
    .operation (alu_op),
    .alternate (alu_alt),
    .src1      (alu_a),
    .src2      (alu_b),
    .q         (alu_q)
  );

  // Result register, ownership, round-robin pointer and lock state.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      q_r      <= '0;
      own      <= '0;
      rsp_pend <= 1'b0;
      rr       <= '0;
      locked   <= 1'b0;
      lock_own <= '0;
    end else begin
      if (accept) begin
        q_r      <= alu_q;
        own      <= gidx;
        rsp_pend <= 1'b1;
        if (!locked) rr <= rr_next;
        if (REQ_LOCK[gidx]) begin
          locked   <= 1'b1;
          lock_own <= gidx;
        end else begin
          locked   <= 1'b0;
        end
      end else begin
        if (drain) rsp_pend <= 1'b0;
        // A lock owner that goes idle without asking to keep the lock releases it.
        if (locked && !REQ_VALID[lock_own] && !REQ_LOCK[lock_own]) locked <= 1'b0;
      end
    end
  end

  always_comb begin
    RSP_VALID = '0;
    for (int i = 0; i < N_REQ; i++) begin
      RSP_VALID[i] = rsp_pend & (own == IDX_W'(i));
    end
  end

  assign RSP_Q = q_r;
  assign BUSY  = rsp_pend | locked;

`ifdef LADYBIRD_ALU_ARB_PERF_EN
  // Saturating accept and stall counters.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      PERF_ACCEPT <= '0;
      PERF_STALL  <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (REQ_READY[i] && (PERF_ACCEPT[i] != 32'hFFFF_FFFF)) PERF_ACCEPT[i] <= PERF_ACCEPT[i] + 32'd1;
      end
      if ((|REQ_VALID) && !accept && (PERF_STALL != 32'hFFFF_FFFF)) PERF_STALL <= PERF_STALL + 32'd1;
    end
  end
`endif

  // Simulation-only protocol checks.
  if (SIMULATION) begin : g_sim_chk
    logic [N_REQ-1:0]           hold_q;
    logic [N_REQ-1:0][2:0]      op_q;
    logic [N_REQ-1:0]           alt_q;
    logic [N_REQ-1:0][XLEN-1:0] s1_q, s2_q;

    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) hold_q <= '0;
      else       hold_q <= REQ_VALID & ~REQ_READY;
    end

    always_ff @(posedge CLK) begin
      op_q  <= REQ_OPERATION;
      alt_q <= REQ_ALTERNATE;
      s1_q  <= REQ_SRC1;
      s2_q  <= REQ_SRC2;
    end

    always_ff @(posedge CLK) begin
      if (!RESET) begin
        assert ($onehot0(grant));
        for (int i = 0; i < N_REQ; i++) begin
          if (hold_q[i]) begin
            assert ((REQ_OPERATION[i] == op_q[i]) && (REQ_ALTERNATE[i] == alt_q[i]) &&
                    (REQ_SRC1[i] == s1_q[i]) && (REQ_SRC2[i] == s2_q[i]));
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_ladybird_alu_arbiter.sv
// Self-checking bench for ladybird_alu_arbiter (N_REQ=2, XLEN=32):
// directed table and multi-cycle sequences, then randomized traffic against a reference model.
module tb_ladybird_alu_arbiter;
  localparam int N = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid, req_ready, req_lock, req_alt, rsp_valid, rsp_ready;
  logic [N-1:0][2:0] req_op;
  logic [N-1:0][31:0] src1, src2;
  logic [31:0]       rsp_q;
  logic              busy;
`ifdef LADYBIRD_ALU_ARB_PERF_EN
  logic [N-1:0][31:0] perf_accept;
  logic [31:0]        perf_stall;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ladybird_alu_arbiter #(
    .N_REQ(N), .XLEN(32), .USE_FA_MODULE(1'b1), .SIMULATION(1'b1)
  ) dut (
    .CLK(clk), .RESET(rst),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_LOCK(req_lock),
    .REQ_OPERATION(req_op), .REQ_ALTERNATE(req_alt),
    .REQ_SRC1(src1), .REQ_SRC2(src2),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_Q(rsp_q), .BUSY(busy)
`ifdef LADYBIRD_ALU_ARB_PERF_EN
    , .PERF_ACCEPT(perf_accept), .PERF_STALL(perf_stall)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic alt,
                         input logic [31:0] a, input logic [31:0] b, input logic lk);
    req_op[i] = op; req_alt[i] = alt; src1[i] = a; src2[i] = b; req_lock[i] = lk;
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_lock = '0; req_alt = '0; req_op = '0;
    src1 = '0; src2 = '0; rsp_ready = '1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // Reference model state for the randomized phase.
  bit          m_pend;
  int          m_own, m_rr, m_lock;
  logic [31:0] m_q;
  int          m_acc [N];
  int          m_stall;

  function automatic int model_winner();
    int w;
    int idx;
    w = -1;
    if (m_lock >= 0) begin
      if (req_valid[m_lock]) w = m_lock;
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (w < 0 && req_valid[idx]) w = idx;
      end
    end
    return w;
  endfunction

  typedef struct {
    logic [2:0]  op;
    logic        alt;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int          win;
    bit          acc;
    logic [31:0] exp_rv;
    logic [31:0] exp_rdy;

    tbl[0]  = '{3'd0, 1'b0, 32'd5,          32'd7,  32'd12};
    tbl[1]  = '{3'd0, 1'b1, 32'd10,         32'd3,  32'd7};
    tbl[2]  = '{3'd2, 1'b0, 32'hFFFF_FFFF,  32'd1,  32'd1};
    tbl[3]  = '{3'd3, 1'b0, 32'hFFFF_FFFF,  32'd1,  32'd0};
    tbl[4]  = '{3'd5, 1'b1, 32'h8000_0000,  32'd4,  32'hF800_0000};
    tbl[5]  = '{3'd5, 1'b0, 32'h8000_0000,  32'd4,  32'h0800_0000};
    tbl[6]  = '{3'd1, 1'b0, 32'd1,          32'd31, 32'h8000_0000};
    tbl[7]  = '{3'd4, 1'b0, 32'd6,          32'd3,  32'd5};
    tbl[8]  = '{3'd6, 1'b0, 32'h0000_00F0,  32'h0F, 32'h0000_00FF};
    tbl[9]  = '{3'd7, 1'b0, 32'h0000_00FF,  32'h3C, 32'h0000_003C};
    tbl[10] = '{3'd0, 1'b0, 32'hFFFF_FFFF,  32'd1,  32'd0};
    tbl[11] = '{3'd1, 1'b0, 32'd1,          32'd33, 32'd2};

    // Reset values, with requests present to show REQ_READY is held low.
    idle_inputs();
    req_valid = 2'b11;
    rst = 1'b1;
    settle();
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rsp_q", rsp_q, 32'd0);
    do_reset();

    // Single op.
    set_req(0, 3'd0, 1'b0, 32'd5, 32'd7, 1'b0);
    req_valid = 2'b01;
    settle();
    chk("single_req_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 2'b00;
    settle();
    chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("single_rsp_q", rsp_q, 32'd12);
    step();
    chk("single_rsp_gone", 32'(rsp_valid), 32'd0);
    chk("single_idle_busy", 32'(busy), 32'd0);

    // Operation table, back-to-back on requester 0.
    for (int i = 0; i < 12; i++) begin
      set_req(0, tbl[i].op, tbl[i].alt, tbl[i].a, tbl[i].b, 1'b0);
      req_valid = 2'b01;
      settle();
      chk("tbl_req_ready", 32'(req_ready), 32'd1);
      step();
      chk("tbl_rsp_valid", 32'(rsp_valid), 32'd1);
      chk($sformatf("tbl_q_%0d", i), rsp_q, tbl[i].q);
    end
    req_valid = '0;
    step();

    // Contention: alternating grants, one result per cycle.
    do_reset();
    set_req(0, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    set_req(1, 3'd3, 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    req_valid = 2'b11;
    for (int c = 0; c < 10; c++) begin
      settle();
      chk("cont_req_ready", 32'(req_ready), (c % 2 == 0) ? 32'd1 : 32'd2);
      step();
      chk("cont_rsp_valid", 32'(rsp_valid), (c % 2 == 0) ? 32'd1 : 32'd2);
      chk("cont_rsp_q", rsp_q, (c % 2 == 0) ? 32'd1 : 32'd0);
    end
`ifdef LADYBIRD_ALU_ARB_PERF_EN
    chk("perf_accept0", perf_accept[0], 32'd5);
    chk("perf_accept1", perf_accept[1], 32'd5);
    chk("perf_stall", perf_stall, 32'd0);
`endif
    req_valid = '0;
    step();

    // Back-pressure: undrained result blocks accepts; RSP_READY of non-owner ignored.
    do_reset();
    rsp_ready = 2'b00;
    set_req(1, 3'd5, 1'b1, 32'h8000_0000, 32'd4, 1'b0);
    req_valid = 2'b10;
    settle();
    chk("bp_first_ready", 32'(req_ready), 32'd2);
    step();
    set_req(0, 3'd0, 1'b0, 32'd5, 32'd7, 1'b0);
    req_valid = 2'b01;
    rsp_ready = 2'b01;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("bp_stall_ready", 32'(req_ready), 32'd0);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd2);
      chk("bp_rsp_q", rsp_q, 32'hF800_0000);
      chk("bp_busy", 32'(busy), 32'd1);
      step();
    end
    rsp_ready = 2'b11;
    settle();
    chk("bp_release_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = '0;
    chk("bp_next_valid", 32'(rsp_valid), 32'd1);
    chk("bp_next_q", rsp_q, 32'd12);
    step();

    // Lock: req0 keeps the grant for two ops while req1 waits.
    do_reset();
    set_req(0, 3'd0, 1'b1, 32'd10, 32'd3, 1'b1);
    set_req(1, 3'd0, 1'b0, 32'd100, 32'd200, 1'b0);
    req_valid = 2'b11;
    settle();
    chk("lock_ready0", 32'(req_ready), 32'd1);
    step();
    chk("lock_rsp0_valid", 32'(rsp_valid), 32'd1);
    chk("lock_rsp0_q", rsp_q, 32'd7);
    chk("lock_busy", 32'(busy), 32'd1);
    set_req(0, 3'd4, 1'b0, 32'd6, 32'd3, 1'b0);
    settle();
    chk("lock_ready1", 32'(req_ready), 32'd1);
    step();
    chk("lock_rsp1_valid", 32'(rsp_valid), 32'd1);
    chk("lock_rsp1_q", rsp_q, 32'd5);
    req_valid = 2'b10;
    settle();
    chk("lock_then_req1", 32'(req_ready), 32'd2);
    step();
    chk("lock_req1_valid", 32'(rsp_valid), 32'd2);
    chk("lock_req1_q", rsp_q, 32'd300);
    req_valid = '0;
    step();

    // Reset mid-flight.
    do_reset();
    rsp_ready = 2'b00;
    set_req(0, 3'd0, 1'b0, 32'd5, 32'd7, 1'b0);
    req_valid = 2'b01;
    settle();
    step();
    chk("rmf_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rmf_rsp_q", rsp_q, 32'd12);
    #2;
    rst = 1'b1;
    #1;
    chk("rmf_async_valid", 32'(rsp_valid), 32'd0);
    chk("rmf_async_busy", 32'(busy), 32'd0);
    chk("rmf_async_ready", 32'(req_ready), 32'd0);
    step();
    rst = 1'b0;
    rsp_ready = 2'b11;
    set_req(1, 3'd0, 1'b0, 32'd1, 32'd2, 1'b0);
    req_valid = 2'b10;
    settle();
    chk("rmf_req1_only", 32'(req_ready), 32'd2);
    step();
    chk("rmf_req1_rsp", 32'(rsp_valid), 32'd2);
    chk("rmf_req1_q", rsp_q, 32'd3);
    do_reset();
    set_req(0, 3'd0, 1'b0, 32'd5, 32'd7, 1'b0);
    set_req(1, 3'd0, 1'b0, 32'd1, 32'd2, 1'b0);
    req_valid = 2'b11;
    settle();
    chk("rmf_req0_first", 32'(req_ready), 32'd1);
    step();
    req_valid = '0;
    step();

    // Randomized traffic against the reference model.
    do_reset();
    m_pend = 1'b0; m_own = 0; m_rr = 0; m_lock = -1; m_q = '0; m_stall = 0;
    for (int i = 0; i < N; i++) m_acc[i] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            set_req(i, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom,
                    ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                    ($urandom_range(0, 3) == 0));
            req_valid[i] = 1'b1;
          end else begin
            req_lock[i] = 1'b0;
          end
        end
        rsp_ready[i] = ($urandom_range(0, 3) != 0);
      end
      settle();

      win     = model_winner();
      acc     = (win >= 0) && (!m_pend || rsp_ready[m_own]);
      exp_rdy = acc ? (32'd1 << win) : 32'd0;
      exp_rv  = m_pend ? (32'd1 << m_own) : 32'd0;
      chk("rnd_req_ready", 32'(req_ready), exp_rdy);
      chk("rnd_rsp_valid", 32'(rsp_valid), exp_rv);
      if (m_pend) chk("rnd_rsp_q", rsp_q, m_q);
      chk("rnd_busy", 32'(busy), 32'(m_pend || (m_lock >= 0)));

      if (acc) begin
        m_q = alu_ref(req_op[win], req_alt[win], src1[win], src2[win]);
        if (m_lock < 0) m_rr = (win + 1) % N;
        m_lock = req_lock[win] ? win : -1;
        m_pend = 1'b1;
        m_own  = win;
        m_acc[win]++;
      end else begin
        if (req_valid != '0) m_stall++;
        if (m_pend && rsp_ready[m_own]) m_pend = 1'b0;
        if ((m_lock >= 0) && !req_valid[m_lock] && !req_lock[m_lock]) m_lock = -1;
      end
      step();
      if (acc) req_valid[win] = 1'b0;
    end
`ifdef LADYBIRD_ALU_ARB_PERF_EN
    chk("rnd_perf_accept0", perf_accept[0], 32'(m_acc[0]));
    chk("rnd_perf_accept1", perf_accept[1], 32'(m_acc[1]));
    chk("rnd_perf_stall", perf_stall, 32'(m_stall));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
